// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: wide add/subtract built by walking one shared 8-bit ripple
// slice over the operand, LSB slice first, with the inter-slice carry held in
// a register. Operands are latched on the accepting edge. The result,
// carry-out and signed overflow are presented with a one-cycle done pulse.

// adder_8_bit: plain 8-bit ripple-carry adder slice.
module adder_8_bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);

  // Ripple the carry bit by bit through the slice.
  always_comb begin : ripple
    logic c_v;
    c_v = cin;
    s   = 8'd0;
    for (int i = 0; i < 8; i++) begin
      s[i] = a[i] ^ b[i] ^ c_v;
      c_v  = (a[i] & b[i]) | (c_v & (a[i] ^ b[i]));
    end
    cout = c_v;
  end

endmodule

module adder_seq_ctrl #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 sub,
  input  logic [8*WORDS-1:0]   a,
  input  logic [8*WORDS-1:0]   b,
  output logic                 ready,
  output logic                 done,
  output logic [8*WORDS-1:0]   result,
  output logic                 cout,
  output logic                 overflow
);

  localparam int W     = 8 * WORDS;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nx_s;
  logic             accept_s;
  logic             step_s;

  logic [W-1:0]     opa_r;
  logic [W-1:0]     opb_r;
  logic [W-1:0]     result_r;
  logic [IDX_W-1:0] idx_r;
  logic             cy_r;

  logic [IDX_W+2:0] bit_off_s;
  logic [7:0]       slice_a_s;
  logic [7:0]       slice_b_s;
  logic [7:0]       slice_sum_s;
  logic             slice_c_s;

  // Bit offset of the active slice is idx*8, formed by concatenation so the
  // index is exactly as wide as the operand needs.
  assign bit_off_s = {idx_r, 3'b000};

  // Operand mux: select the active 8-bit slice of each latched operand.
  always_comb begin
    slice_a_s = opa_r[bit_off_s +: 8];
    slice_b_s = opb_r[bit_off_s +: 8];
  end

  adder_8_bit u_slice (
    .a    (slice_a_s),
    .b    (slice_b_s),
    .cin  (cy_r),
    .s    (slice_sum_s),
    .cout (slice_c_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic and per-cycle datapath strobes.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    step_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          accept_s   = 1'b1;
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        step_s = 1'b1;
        if (idx_r == LAST_IDX) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_IDLE;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Datapath: latch operands on accept, then write one slice per RUN cycle.
  // Subtraction is folded in here: B is inverted and the carry seeded with 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opa_r    <= {W{1'b0}};
      opb_r    <= {W{1'b0}};
      result_r <= {W{1'b0}};
      idx_r    <= {IDX_W{1'b0}};
      cy_r     <= 1'b0;
    end else if (accept_s) begin
      opa_r    <= a;
      opb_r    <= b ^ {W{sub}};
      result_r <= {W{1'b0}};
      idx_r    <= {IDX_W{1'b0}};
      cy_r     <= sub;
    end else if (step_s) begin
      result_r[bit_off_s +: 8] <= slice_sum_s;
      cy_r                     <= slice_c_s;
      if (idx_r != LAST_IDX) begin
        idx_r <= idx_r + IDX_W'(1);
      end else begin
        idx_r <= idx_r;
      end
    end else begin
      opa_r    <= opa_r;
      opb_r    <= opb_r;
      result_r <= result_r;
      idx_r    <= idx_r;
      cy_r     <= cy_r;
    end
  end

  // Handshake outputs are pure decodes of the state register.
  assign ready  = (state_r == ST_IDLE);
  assign done   = (state_r == ST_DONE);
  assign result = result_r;

  // The carry register holds the final MSB-slice carry from DONE until the
  // next accept, so it doubles as cout.
  assign cout = cy_r;

  // Signed overflow: operands (as actually added) agree in sign but the
  // result does not.
  assign overflow = (opa_r[W-1] == opb_r[W-1]) && (result_r[W-1] != opa_r[W-1]);

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl: a WORDS=4 and a WORDS=2 instance.
module tb_adder_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        start, sub;
  logic [31:0] a, b, result;
  logic        ready, done, cout, overflow;

  logic        start2, sub2;
  logic [15:0] a2, b2, result2;
  logic        ready2, done2, cout2, overflow2;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] pa4 [4] = '{32'h0000_0001, 32'h1000_0000, 32'h89AB_CDEF, 32'h0000_0000};
  logic [31:0] pb4 [4] = '{32'h0000_0002, 32'h0000_0001, 32'h1111_1111, 32'h0000_0001};
  logic        ps4 [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] pe4 [4] = '{32'h0000_0003, 32'h0FFF_FFFF, 32'h9ABC_DF00, 32'hFFFF_FFFF};

  logic [15:0] pa2 [4] = '{16'h00FF, 16'h1234, 16'hFFFF, 16'h8000};
  logic [15:0] pb2 [4] = '{16'h0001, 16'h0235, 16'h0001, 16'h0001};
  logic        ps2 [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic [15:0] pe2 [4] = '{16'h0100, 16'h0FFF, 16'h0000, 16'h7FFF};

  always #5 clk = ~clk;

  adder_seq_ctrl #(.WORDS(4)) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  adder_seq_ctrl #(.WORDS(2)) u_dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start2),
    .sub      (sub2),
    .a        (a2),
    .b        (b2),
    .ready    (ready2),
    .done     (done2),
    .result   (result2),
    .cout     (cout2),
    .overflow (overflow2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // One operation on the WORDS=4 instance, checking latency and outputs.
  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic sv, input logic [31:0] er, input logic ec, input logic eo);
    int n;
    int busy_bad;
    check({tag, ":ready_before"}, ready, 32'd1);
    a = av; b = bv; sub = sv; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = ~av; b = $urandom; sub = ~sv;
    n = 0; busy_bad = 0;
    while (done !== 1'b1 && n < 20) begin
      if (ready !== 1'b0) busy_bad++;
      @(negedge clk);
      n++;
    end
    check({tag, ":latency"}, n, 32'd4);
    check({tag, ":ready_low_in_run"}, busy_bad, 32'd0);
    check({tag, ":result"}, result, er);
    check({tag, ":cout"}, cout, {31'd0, ec});
    check({tag, ":overflow"}, overflow, {31'd0, eo});
    check({tag, ":ready_at_done"}, ready, 32'd0);
    @(negedge clk);
    check({tag, ":ready_after"}, ready, 32'd1);
    check({tag, ":done_after"}, done, 32'd0);
    check({tag, ":result_hold"}, result, er);
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d, k, last, dones, rlow;

    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = 32'd0; b = 32'd0;
    start2 = 1'b0; sub2 = 1'b0; a2 = 16'd0; b2 = 16'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst:ready", ready, 32'd1);
    check("rst:done", done, 32'd0);
    check("rst:result", result, 32'd0);
    check("rst:cout", cout, 32'd0);
    check("rst:overflow", overflow, 32'd0);
    check("rst:ready2", ready2, 32'd1);

    // Main function
    run_op("add_carry", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    run_op("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op("sub_borrow",32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    run_op("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Busy protection: start pulse during RUN must be ignored
    a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dones = 0; rlow = 0;
    for (int i = 0; i < 16; i++) begin
      if (done === 1'b1) dones++;
      if (ready === 1'b0) rlow++;
      if (i == 1) begin
        start = 1'b1; a = 32'd0; b = 32'd0;
      end else begin
        start = 1'b0; a = $urandom; b = $urandom;
      end
      @(negedge clk);
    end
    check("busy:result", result, 32'h2345_6789);
    check("busy:done_count", dones, 32'd1);
    check("busy:ready_low_cycles", rlow, 32'd5);
    check("busy:ready_end", ready, 32'd1);

    // Reset mid-operation, after slices 0 and 1 have been written
    a = 32'hFFFF_FFFF; b = 32'h0000_0001; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst:ready", ready, 32'd1);
    check("midrst:done", done, 32'd0);
    check("midrst:result", result, 32'd0);
    check("midrst:cout", cout, 32'd0);
    run_op("after_rst", 32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0);

    // Back-to-back, WORDS=4: start held high
    d = 0; k = 0; last = 0;
    for (int c = 0; c < 60 && d < 4; c++) begin
      if (done === 1'b1) begin
        check($sformatf("b2b4:result%0d", d), result, pe4[d]);
        if (d > 0) check($sformatf("b2b4:spacing%0d", d), c - last, 32'd6);
        last = c;
        d++;
      end
      if (ready === 1'b1 && k < 4) begin
        a = pa4[k]; b = pb4[k]; sub = ps4[k]; start = 1'b1;
        k++;
      end else if (ready === 1'b1) begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("b2b4:done_count", d, 32'd4);

    // Back-to-back, WORDS=2
    d = 0; k = 0; last = 0;
    for (int c = 0; c < 60 && d < 4; c++) begin
      if (done2 === 1'b1) begin
        check($sformatf("b2b2:result%0d", d), {16'd0, result2}, {16'd0, pe2[d]});
        if (d > 0) check($sformatf("b2b2:spacing%0d", d), c - last, 32'd4);
        last = c;
        d++;
      end
      if (ready2 === 1'b1 && k < 4) begin
        a2 = pa2[k]; b2 = pb2[k]; sub2 = ps2[k]; start2 = 1'b1;
        k++;
      end else if (ready2 === 1'b1) begin
        start2 = 1'b0;
      end
      @(negedge clk);
    end
    start2 = 1'b0;
    check("b2b2:done_count", d, 32'd4);
    check("b2b2:last_cout", cout2, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
